// File: rtl/uart_tx_framer.sv
// Payload FIFO plus frame sequencer: sends HEADER, LEN, payload bytes (and CHK when
// UART_FRAMER_CHECKSUM_EN is defined) to an EN/busy byte sender, with ack timeout.
module uart_tx_framer #(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter logic [7:0]  HEADER      = 8'hA5,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic                        CLK_SYS,
   input  logic                        CLK_RST,
   input  logic                        Wr_en,
   input  logic [7:0]                  Wr_data,
   output logic                        Fifo_full,
   output logic [$clog2(FIFO_DEPTH):0] Fifo_level,
   input  logic                        Frame_go,
   output logic                        Frame_busy,
   output logic                        Overflow,
   output logic                        Timeout_err,
   input  logic                        Err_clr,
   output logic                        Uart_TX_EN,
   output logic [7:0]                  Uart_din,
   input  logic                        Uart_TX_busy
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, LOAD, EN_HI, WAIT_DONE, GAP, FLUSH} state_e;
   typedef enum logic [2:0] {SEL_HDR, SEL_LEN, SEL_PAY, SEL_CHK, SEL_END} sel_e;

`ifdef UART_FRAMER_CHECKSUM_EN
   localparam sel_e SEL_TAIL = SEL_CHK;
`else
   localparam sel_e SEL_TAIL = SEL_END;
`endif

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic [7:0]       head;
   logic             full, push, pop;

   state_e           state_q;
   sel_e             sel_q;
   logic [LVL_W-1:0] rem_q;
   logic [TMR_W-1:0] tmr_q;
   logic             gap_q;
   logic             tx_en_q;
   logic [7:0]       din_q;
   logic             ovf_q, tmo_q;
`ifdef UART_FRAMER_CHECKSUM_EN
   logic [7:0]       chk_q;
`endif

   assign full = (level_q == LVL_W'(FIFO_DEPTH));
   assign head = mem_q[rd_ptr_q];
   // A pop in the same cycle frees a slot, so a write while full is still accepted.
   assign push = Wr_en && (!full || pop);
   assign pop  = ((state_q == LOAD) && (sel_q == SEL_PAY)) ||
                 ((state_q == FLUSH) && (rem_q != '0));

   // NOTE: the byte array has no reset; emptiness is defined by the pointers and level only.
   always_ff @(posedge CLK_SYS) begin
      if (push) mem_q[wr_ptr_q] <= Wr_data;
   end

   // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
      if (CLK_RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
      if (CLK_RST) begin
         state_q <= IDLE;
         sel_q   <= SEL_HDR;
         rem_q   <= '0;
         tmr_q   <= '0;
         gap_q   <= 1'b0;
         tx_en_q <= 1'b0;
         din_q   <= 8'h00;
`ifdef UART_FRAMER_CHECKSUM_EN
         chk_q   <= 8'h00;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (Frame_go) begin
                  state_q <= LOAD;
                  sel_q   <= SEL_HDR;
                  rem_q   <= level_q;
`ifdef UART_FRAMER_CHECKSUM_EN
                  chk_q   <= 8'(level_q);
`endif
               end
            end
            LOAD: begin
               state_q <= EN_HI;
               tx_en_q <= 1'b1;
               tmr_q   <= '0;
               case (sel_q)
                  SEL_HDR: begin
                     din_q <= HEADER;
                     sel_q <= SEL_LEN;
                  end
                  SEL_LEN: begin
                     din_q <= 8'(rem_q);
                     sel_q <= (rem_q != '0) ? SEL_PAY : SEL_TAIL;
                  end
                  SEL_PAY: begin
                     din_q <= head;
                     rem_q <= rem_q - LVL_W'(1);
                     sel_q <= (rem_q == LVL_W'(1)) ? SEL_TAIL : SEL_PAY;
`ifdef UART_FRAMER_CHECKSUM_EN
                     chk_q <= chk_q ^ head;
`endif
                  end
`ifdef UART_FRAMER_CHECKSUM_EN
                  SEL_CHK: begin
                     din_q <= chk_q;
                     sel_q <= SEL_END;
                  end
`endif
                  default: begin
                     state_q <= IDLE;
                     tx_en_q <= 1'b0;
                  end
               endcase
            end
            EN_HI: begin
               if (Uart_TX_busy) begin
                  state_q <= WAIT_DONE;
                  tx_en_q <= 1'b0;
               end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                  state_q <= FLUSH;
                  tx_en_q <= 1'b0;
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
            end
            WAIT_DONE: begin
               if (!Uart_TX_busy) begin
                  state_q <= GAP;
                  gap_q   <= 1'b0;
               end
            end
            GAP: begin
               if (gap_q) state_q <= (sel_q == SEL_END) ? IDLE : LOAD;
               else       gap_q   <= 1'b1;
            end
            FLUSH: begin
               // Discard the unsent payload of this frame only; later writes stay queued.
               if (rem_q != '0)          rem_q   <= rem_q - LVL_W'(1);
               if (rem_q <= LVL_W'(1))   state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
      if (CLK_RST) begin
         ovf_q <= 1'b0;
         tmo_q <= 1'b0;
      end else begin
         if (Wr_en && !push)     ovf_q <= 1'b1;
         else if (Err_clr)       ovf_q <= 1'b0;
         if (state_q == FLUSH)   tmo_q <= 1'b1;
         else if (Err_clr)       tmo_q <= 1'b0;
      end
   end

   assign Fifo_full   = full;
   assign Fifo_level  = level_q;
   assign Frame_busy  = (state_q != IDLE);
   assign Overflow    = ovf_q;
   assign Timeout_err = tmo_q;
   assign Uart_TX_EN  = tx_en_q;
   assign Uart_din    = din_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer with a byte-sender model; expects CHK bytes only
// when UART_FRAMER_CHECKSUM_EN is defined.
module tb_uart_tx_framer;
   logic       CLK_SYS = 1'b0;
   logic       CLK_RST = 1'b1;
   logic       Wr_en = 1'b0;
   logic [7:0] Wr_data = 8'h00;
   logic       Fifo_full;
   logic [4:0] Fifo_level;
   logic       Frame_go = 1'b0;
   logic       Frame_busy;
   logic       Overflow;
   logic       Timeout_err;
   logic       Err_clr = 1'b0;
   logic       Uart_TX_EN;
   logic [7:0] Uart_din;
   logic       Uart_TX_busy;

   int         n_checks = 0;
   int         n_errors = 0;

   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   int         rise_cyc[$];
   int         cyc_cnt = 0;
   int         rises = 0;
   int         acked = 0;
   int         ack_limit = 1000;
   int         busy_cnt = 0;
   logic       en_prev = 1'b0;

   uart_tx_framer #(.FIFO_DEPTH(16), .HEADER(8'hA5), .ACK_TIMEOUT(15)) dut (
      .CLK_SYS     (CLK_SYS),
      .CLK_RST     (CLK_RST),
      .Wr_en       (Wr_en),
      .Wr_data     (Wr_data),
      .Fifo_full   (Fifo_full),
      .Fifo_level  (Fifo_level),
      .Frame_go    (Frame_go),
      .Frame_busy  (Frame_busy),
      .Overflow    (Overflow),
      .Timeout_err (Timeout_err),
      .Err_clr     (Err_clr),
      .Uart_TX_EN  (Uart_TX_EN),
      .Uart_din    (Uart_din),
      .Uart_TX_busy(Uart_TX_busy)
   );

   initial forever #5 CLK_SYS = ~CLK_SYS;

   // Sender model: captures Uart_din on each EN rise and holds busy for 3 cycles.
   initial begin
      Uart_TX_busy = 1'b0;
      forever begin
         @(negedge CLK_SYS);
         cyc_cnt++;
         if (busy_cnt > 0) begin
            busy_cnt--;
            Uart_TX_busy = (busy_cnt != 0);
         end
         if (Uart_TX_EN && !en_prev) begin
            rises++;
            rise_cyc.push_back(cyc_cnt);
            if (acked < ack_limit) begin
               got.push_back(Uart_din);
               acked++;
               busy_cnt     = 3;
               Uart_TX_busy = 1'b1;
            end
         end
         en_prev = Uart_TX_EN;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] b);
      Wr_en   = 1'b1;
      Wr_data = b;
      @(negedge CLK_SYS);
      Wr_en   = 1'b0;
   endtask

   task automatic go();
      Frame_go = 1'b1;
      @(negedge CLK_SYS);
      Frame_go = 1'b0;
   endtask

   task automatic clr();
      Err_clr = 1'b1;
      @(negedge CLK_SYS);
      Err_clr = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (Frame_busy && n < budget) begin
         @(negedge CLK_SYS);
         n++;
      end
      repeat (2) @(negedge CLK_SYS);
      check("idle_bound", Frame_busy, 1'b0);
   endtask

   task automatic e(input logic [7:0] b);
      exp_q.push_back(b);
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
   endtask

   task automatic restart_capture();
      got.delete();
      exp_q.delete();
      rise_cyc.delete();
      rises = 0;
      acked = 0;
   endtask

   initial begin
      logic [7:0] chk;
      int         n;

      // Reset values
      repeat (2) @(negedge CLK_SYS);
      check("rst_level", Fifo_level, 5'd0);
      check("rst_full", Fifo_full, 1'b0);
      check("rst_busy", Frame_busy, 1'b0);
      check("rst_ovf", Overflow, 1'b0);
      check("rst_tmo", Timeout_err, 1'b0);
      check("rst_en", Uart_TX_EN, 1'b0);
      check("rst_din", Uart_din, 8'h00);
      CLK_RST = 1'b0;
      @(negedge CLK_SYS);

      // Basic frame 03,7F,10 with latency and inter-byte spacing
      restart_capture();
      wr(8'h03); wr(8'h7F); wr(8'h10);
      check("f1_level", Fifo_level, 5'd3);
      go();
      check("f1_busy", Frame_busy, 1'b1);
      @(negedge CLK_SYS);
      check("f1_lat_en", Uart_TX_EN, 1'b1);
      check("f1_lat_din", Uart_din, 8'hA5);
      wait_idle(400);
      e(8'hA5); e(8'h03); e(8'h03); e(8'h7F); e(8'h10);
`ifdef UART_FRAMER_CHECKSUM_EN
      e(8'h6F);
`endif
      check_frame("f1");
      check("f1_spacing", rise_cyc[1] - rise_cyc[0], 7);
      check("f1_level_end", Fifo_level, 5'd0);

      // Empty frame
      restart_capture();
      go();
      wait_idle(200);
      e(8'hA5); e(8'h00);
`ifdef UART_FRAMER_CHECKSUM_EN
      e(8'h00);
`endif
      check_frame("f0");

      // LEN snapshot: late write stays queued, second Frame_go ignored
      restart_capture();
      wr(8'h11); wr(8'h22);
      go();
      wr(8'h33);
      go();
      wait_idle(400);
      e(8'hA5); e(8'h02); e(8'h11); e(8'h22);
`ifdef UART_FRAMER_CHECKSUM_EN
      e(8'h31);
`endif
      check_frame("snap");
      check("snap_level", Fifo_level, 5'd1);
      restart_capture();
      go();
      wait_idle(400);
      e(8'hA5); e(8'h01); e(8'h33);
`ifdef UART_FRAMER_CHECKSUM_EN
      e(8'h32);
`endif
      check_frame("left");
      check("left_level", Fifo_level, 5'd0);

      // Overflow, Err_clr, set-over-clear priority
      for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i));
      check("ovf_full", Fifo_full, 1'b1);
      check("ovf_level16", Fifo_level, 5'd16);
      check("ovf_not_yet", Overflow, 1'b0);
      wr(8'h50);
      check("ovf_set", Overflow, 1'b1);
      check("ovf_level_kept", Fifo_level, 5'd16);
      clr();
      check("ovf_clr", Overflow, 1'b0);
      Err_clr = 1'b1;
      wr(8'h51);
      Err_clr = 1'b0;
      check("ovf_prio", Overflow, 1'b1);
      clr();
      check("ovf_clr2", Overflow, 1'b0);

      // Write while full in the first payload pop cycle (Frame_go + 15) is accepted
      restart_capture();
      go();
      repeat (14) @(negedge CLK_SYS);
      wr(8'h60);
      check("popwr_level", Fifo_level, 5'd16);
      check("popwr_ovf", Overflow, 1'b0);
      wait_idle(600);
      chk = 8'h10;
      e(8'hA5); e(8'h10);
      for (int i = 0; i < 16; i++) begin
         e(8'h40 + 8'(i));
         chk ^= 8'h40 + 8'(i);
      end
`ifdef UART_FRAMER_CHECKSUM_EN
      e(chk);
`endif
      check_frame("full");
      check("full_left", Fifo_level, 5'd1);
      check("full_not_full", Fifo_full, 1'b0);

      // Ack timeout with 4 queued bytes
      restart_capture();
      wr(8'h61); wr(8'h62); wr(8'h63);
      check("tmo_level4", Fifo_level, 5'd4);
      ack_limit = 0;
      go();
      @(negedge CLK_SYS);
      check("tmo_en", Uart_TX_EN, 1'b1);
      repeat (15) @(negedge CLK_SYS);
      check("tmo_early", Timeout_err, 1'b0);
      @(negedge CLK_SYS);
      check("tmo_set", Timeout_err, 1'b1);
      check("tmo_en_low", Uart_TX_EN, 1'b0);
      wait_idle(100);
      check("tmo_level0", Fifo_level, 5'd0);
      check("tmo_no_bytes", got.size(), 0);
      clr();
      check("tmo_clr", Timeout_err, 1'b0);

      // Reset while a payload byte waits in EN_HI
      restart_capture();
      ack_limit = 2;
      wr(8'hC1); wr(8'hC2);
      go();
      n = 0;
      while (!(rises == 3 && Uart_TX_EN) && n < 200) begin
         @(negedge CLK_SYS);
         #1;
         n++;
      end
      check("mrst_reached", (rises == 3) && Uart_TX_EN, 1'b1);
      check("mrst_pre_level", Fifo_level, 5'd1);
      CLK_RST = 1'b1;
      #1;
      check("mrst_en", Uart_TX_EN, 1'b0);
      check("mrst_level", Fifo_level, 5'd0);
      check("mrst_busy", Frame_busy, 1'b0);
      check("mrst_din", Uart_din, 8'h00);
      @(negedge CLK_SYS);
      CLK_RST = 1'b0;
      restart_capture();
      ack_limit = 1000;
      @(negedge CLK_SYS);
      go();
      wait_idle(200);
      e(8'hA5); e(8'h00);
`ifdef UART_FRAMER_CHECKSUM_EN
      e(8'h00);
`endif
      check_frame("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
